// File: rtl/c1_wr_arbiter.sv
// Round-robin arbiter sharing the CCI-P channel-1 write port among N_REQ requesters.
// Caps in-flight writes, routes responses back by mdata, and supports a drain-to-idle sequence.
module c1_wr_arbiter #(
  parameter int N_REQ           = 4,
  parameter int ADDR_W          = 42,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      c1TxAlmFull,
  output logic                      wr_valid,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [15:0]               wr_mdata,
  input  logic                      wr_rsp_valid,
  input  logic [15:0]               wr_rsp_mdata,
  output logic [N_REQ-1:0]          rsp_done,
  output logic [6:0]                outstanding,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [6:0] OUT_MAX = 7'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [15:0]         wr_mdata_q;
  logic [N_REQ-1:0]    rsp_done_q;
  logic [6:0]          outstanding_q;
  logic                err_q;

  logic                run_en;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic [IDX_W:0]      cand_sum;
  logic [IDX_W-1:0]    cand;
  logic                grant;
  logic                rsp_in_range;
  logic                rsp_counted;

  // Scan offsets from highest to lowest so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (cand_sum >= (IDX_W + 1)'(N_REQ)) begin
        cand_sum = cand_sum - (IDX_W + 1)'(N_REQ);
      end
      cand = cand_sum[IDX_W-1:0];
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Reset gates the grant so req_ready drops the moment reset is asserted.
  assign grant = run_en && !reset && !c1TxAlmFull && (outstanding_q < OUT_MAX) && win_found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign rsp_in_range = (wr_rsp_mdata < 16'(N_REQ));
  assign rsp_counted  = wr_rsp_valid && (outstanding_q != 7'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_mdata_q    <= '0;
      rsp_done_q    <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      wr_valid_q <= grant;
      if (grant) begin
        wr_addr_q  <= req_addr[win_idx*ADDR_W +: ADDR_W];
        wr_data_q  <= req_data[win_idx*DATA_W +: DATA_W];
        wr_mdata_q <= 16'(win_idx);
        rr_ptr_q   <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end

      rsp_done_q <= '0;
      if (wr_rsp_valid && rsp_in_range) begin
        rsp_done_q[wr_rsp_mdata[IDX_W-1:0]] <= 1'b1;
      end

      case ({grant, rsp_counted})
        2'b10:   outstanding_q <= outstanding_q + 7'd1;
        2'b01:   outstanding_q <= outstanding_q - 7'd1;
        default: outstanding_q <= outstanding_q;
      endcase

      // Spurious responses (nothing in flight, or unknown owner) latch the error.
      if (wr_rsp_valid && ((outstanding_q == 7'd0) || !rsp_in_range)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if ((outstanding_q == 7'd0) && !wr_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    run_en     = (state_q == ST_RUN);
    drain_done = (state_q == ST_DONE);
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_mdata    = wr_mdata_q;
  assign rsp_done    = rsp_done_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

endmodule

// File: tb/tb_c1_wr_arbiter.sv
// Self-checking bench for c1_wr_arbiter: directed scenarios followed by a randomized run,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_c1_wr_arbiter;

  localparam int N    = 4;
  localparam int AW   = 42;
  localparam int DW   = 512;
  localparam int MAXO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            c1TxAlmFull;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [15:0]     wr_mdata;
  logic            wr_rsp_valid;
  logic [15:0]     wr_rsp_mdata;
  logic [N-1:0]    rsp_done;
  logic [6:0]      outstanding;
  logic            drain_req;
  logic            drain_done;
  logic            err;

  always #5 clk = ~clk;

  c1_wr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .c1TxAlmFull(c1TxAlmFull),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mdata(wr_mdata),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_mdata(wr_rsp_mdata), .rsp_done(rsp_done),
    .outstanding(outstanding), .drain_req(drain_req), .drain_done(drain_done), .err(err)
  );

  logic [AW-1:0] a_slot [N];
  logic [DW-1:0] d_slot [N];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a_slot[i];
      req_data[i*DW +: DW] = d_slot[i];
    end
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: 0=run, 1=draining, 2=drain complete
  int            m_rr, m_out, m_state, m_mdata;
  bit            m_err, m_wv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_done;
  int            issued[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] v;
    v = {10'($urandom), 32'($urandom)};
    return v;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_out = 0; m_state = 0; m_mdata = 0;
    m_err = 1'b0; m_wv = 1'b0; m_addr = '0; m_data = '0; m_done = '0;
    issued.delete();
  endtask

  // One clock: check the combinational grant, advance the model at the edge, check registered outputs.
  task automatic cycle();
    int w, ns;
    bit dec;
    logic [N-1:0] exp_rdy;
    #1;
    w = (m_state == 0 && !c1TxAlmFull && m_out < MAXO) ? pick() : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    if (m_state == 0 && drain_req) ns = 1;
    else if (m_state == 1 && m_out == 0 && !m_wv) ns = 2;
    else if (m_state == 2) ns = 0;
    else ns = m_state;
    m_done = '0;
    dec = 1'b0;
    if (wr_rsp_valid) begin
      if (wr_rsp_mdata < N) m_done[wr_rsp_mdata] = 1'b1;
      else m_err = 1'b1;
      if (m_out == 0) m_err = 1'b1;
      else dec = 1'b1;
    end
    m_out = m_out + ((w >= 0) ? 1 : 0) - (dec ? 1 : 0);
    m_wv = (w >= 0);
    if (w >= 0) begin
      m_addr = a_slot[w];
      m_data = d_slot[w];
      m_mdata = w;
      m_rr = (w + 1) % N;
      issued.push_back(w);
    end
    m_state = ns;
    #1;
    chk("wr_valid", wr_valid, m_wv);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("wr_mdata", wr_mdata, 16'(m_mdata));
    chk("outstanding", outstanding, 7'(m_out));
    chk("rsp_done", rsp_done, m_done);
    chk("err", err, m_err);
    chk("drain_done", drain_done, (m_state == 2));
  endtask

  // Asserts reset between edges and checks that outputs clear before any clock edge.
  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_outstanding", outstanding, 7'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_done", rsp_done, '0);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int dd, j;
    reset = 1'b1; req_valid = '0; c1TxAlmFull = 1'b0;
    wr_rsp_valid = 1'b0; wr_rsp_mdata = '0; drain_req = 1'b0;
    for (int i = 0; i < N; i++) begin a_slot[i] = rnd_addr(); d_slot[i] = rnd_data(); end
    @(posedge clk); #1;
    do_reset();

    // Single requester, then its response
    a_slot[2] = 42'h1000;
    req_valid = 4'b0100; cycle();
    chk("t1_addr", wr_addr, 42'h1000);
    chk("t1_mdata", wr_mdata, 16'd2);
    req_valid = '0; cycle();
    wr_rsp_valid = 1'b1; wr_rsp_mdata = 16'd2; cycle();
    chk("t1_rsp_done", rsp_done, 4'b0100);
    wr_rsp_valid = 1'b0; cycle();

    // All requesters contending: strict rotation
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t2_order", wr_mdata, 16'(i % 4));
    end
    chk("t2_outstanding", outstanding, 7'd8);

    // Almost-full back-pressure
    c1TxAlmFull = 1'b1;
    repeat (5) cycle();
    c1TxAlmFull = 1'b0; cycle();
    chk("t3_first_after_almfull", wr_valid, 1'b1);

    // Outstanding cap
    repeat (10) cycle();
    chk("t4_cap", outstanding, 7'd16);
    wr_rsp_valid = 1'b1; wr_rsp_mdata = 16'd0; cycle();
    wr_rsp_valid = 1'b0; cycle();
    chk("t4_regrant", wr_valid, 1'b1);
    wr_rsp_valid = 1'b1; wr_rsp_mdata = 16'd1; cycle();
    wr_rsp_mdata = 16'd2; cycle();
    chk("t4_simul", outstanding, 7'd15);
    wr_rsp_valid = 1'b0; req_valid = '0; cycle();

    // Drain with three writes in flight
    do_reset();
    req_valid = 4'hF;
    repeat (3) cycle();
    req_valid = '0; drain_req = 1'b1; cycle();
    drain_req = 1'b0; req_valid = 4'b0010;
    dd = 0;
    for (int i = 0; i < 3; i++) begin
      wr_rsp_valid = 1'b1; wr_rsp_mdata = 16'(i);
      drain_req = (i == 1);
      cycle();
      dd += int'(drain_done);
    end
    wr_rsp_valid = 1'b0; drain_req = 1'b0;
    for (int i = 0; i < 6; i++) begin cycle(); dd += int'(drain_done); end
    chk("t5_drain_pulses", 32'(dd), 32'd1);
    req_valid = '0; cycle();

    // Spurious responses and mid-burst reset
    do_reset();
    wr_rsp_valid = 1'b1; wr_rsp_mdata = 16'd0; cycle();
    wr_rsp_valid = 1'b0; repeat (2) cycle();
    chk("t6_err_sticky", err, 1'b1);
    do_reset();
    req_valid = 4'b0001; cycle();
    req_valid = '0; wr_rsp_valid = 1'b1; wr_rsp_mdata = 16'd7; cycle();
    chk("t6_bad_mdata_err", err, 1'b1);
    wr_rsp_valid = 1'b0; cycle();
    req_valid = 4'hF;
    repeat (3) cycle();
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      c1TxAlmFull = ($urandom_range(0, 4) == 0);
      drain_req = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, N - 1);
        a_slot[j] = rnd_addr();
        d_slot[j] = rnd_data();
      end
      wr_rsp_valid = 1'b0;
      if (issued.size() > 0 && $urandom_range(0, 2) != 0) begin
        j = $urandom_range(0, issued.size() - 1);
        wr_rsp_valid = 1'b1;
        wr_rsp_mdata = 16'(issued[j]);
        issued.delete(j);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
